vc_dest_arbiter: RTL

//  Downstream stage of the two virtual-channel FIFOs (VC0, VC1) in the transmit path.

---
 rtl/vc_arb_pkg.sv | 23 ++
 rtl/vc_arb_push_counter.sv | 31 +++
 rtl/vc_dest_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vc_arb_pkg.sv
// Shared types and constants for the VC-to-destination arbiter.
// Optional round-robin tie-break is enabled with `define VC_ARB_RR_EN.
package vc_arb_pkg;
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_e;

    localparam int NUM_DEST   = 4;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_CNT_W  = 5;
    localparam int DEST_MSB   = DEF_DATA_W - 1;
    localparam int DEST_LSB   = DEF_DATA_W - 2;
    localparam int DEST_W     = DEST_MSB - DEST_LSB + 1;

    function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_W-1:0] d);
        logic [NUM_DEST-1:0] r;
        r    = '0;
        r[d] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/vc_arb_push_counter.sv
// Wrapping push counter for one destination; holds unless inc is high.
module vc_arb_push_counter
    import vc_arb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/vc_dest_arbiter.sv
// Pops VC0/VC1, routes each word by its top two bits to one of four destinations.
// `define VC_ARB_RR_EN switches the VC tie-break from strict VC0 priority to round-robin.
module vc_dest_arbiter
    import vc_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  logic [DATA_W-1:0]   vc0_head,
    input  logic [DATA_W-1:0]   vc1_head,
    input  logic [DATA_W-1:0]   vc0_data,
    input  logic [DATA_W-1:0]   vc1_data,
    input  logic [NUM_DEST-1:0] dest_full,
    input  logic [NUM_DEST-1:0] dest_almost_full,
    output logic                vc0_pop,
    output logic                vc1_pop,
    output logic [NUM_DEST-1:0] dest_push,
    output logic [DATA_W-1:0]   dest_data,
    input  logic [DEST_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]    cnt_out,
    output logic                idle
);
    arb_state_e          state_q, state_d;
    logic                pop0_q, pop0_d, pop1_q, pop1_d;
    logic [DEST_W-1:0]   dest1_q, dest1_d;
    logic                v2_q, v2_d, sel2_q, sel2_d;
    logic [DEST_W-1:0]   dest2_q, dest2_d;
    logic [NUM_DEST-1:0] push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [DEST_W-1:0] d0, d1;
    logic              run, elig0, elig1, grant0, grant1;
    logic              unused_head_bits;

    assign d0 = vc0_head[DATA_W-1 -: DEST_W];
    assign d1 = vc1_head[DATA_W-1 -: DEST_W];
    assign unused_head_bits = ^{vc0_head[DATA_W-DEST_W-1:0], vc1_head[DATA_W-DEST_W-1:0]};

`ifdef VC_ARB_RR_EN
    logic last1_q, last1_d;
`endif

    // A VC popped this cycle still shows the popped word as its head, so it sits out one cycle.
    always_comb begin
        run    = init && (state_q != ST_INIT);
        elig0  = run && !vc0_empty && !dest_full[d0] && !dest_almost_full[d0] && !pop0_q;
        elig1  = run && !vc1_empty && !dest_full[d1] && !dest_almost_full[d1] && !pop1_q;
        grant0 = elig0;
        grant1 = elig1 && !elig0;
`ifdef VC_ARB_RR_EN
        if (elig0 && elig1) begin
            grant0 = last1_q;
            grant1 = !last1_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        pop0_d  = grant0;
        pop1_d  = grant1;
        dest1_d = grant1 ? d1 : d0;
        v2_d    = pop0_q || pop1_q;
        sel2_d  = pop1_q;
        dest2_d = dest1_q;
        push_d  = v2_q ? dest_onehot(dest2_q) : '0;
        data_d  = !v2_q ? '0 : (sel2_q ? vc1_data : vc0_data);
`ifdef VC_ARB_RR_EN
        last1_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : last1_q);
`endif
        case (state_q)
            ST_INIT:   if (init) state_d = ST_IDLE;
            ST_IDLE:   if (grant0 || grant1) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!grant0 && !grant1 && !pop0_q && !pop1_q && !v2_q) state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
        // Dropping init abandons whatever is in flight; counters are left alone.
        if (!init) begin
            state_d = ST_INIT;
            pop0_d  = 1'b0;
            pop1_d  = 1'b0;
            v2_d    = 1'b0;
            push_d  = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
            pop0_q  <= 1'b0;
            pop1_q  <= 1'b0;
            dest1_q <= '0;
            v2_q    <= 1'b0;
            sel2_q  <= 1'b0;
            dest2_q <= '0;
            push_q  <= '0;
            data_q  <= '0;
`ifdef VC_ARB_RR_EN
            last1_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            pop0_q  <= pop0_d;
            pop1_q  <= pop1_d;
            dest1_q <= dest1_d;
            v2_q    <= v2_d;
            sel2_q  <= sel2_d;
            dest2_q <= dest2_d;
            push_q  <= push_d;
            data_q  <= data_d;
`ifdef VC_ARB_RR_EN
            last1_q <= last1_d;
`endif
        end
    end

    logic [CNT_W-1:0] cnt [NUM_DEST];

    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_cnt
        vc_arb_push_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (push_q[gi]),
            .count (cnt[gi])
        );
    end

    assign vc0_pop   = pop0_q;
    assign vc1_pop   = pop1_q;
    assign dest_push = push_q;
    assign dest_data = data_q;
    assign cnt_out   = cnt[cnt_sel];
    assign idle      = (state_q == ST_IDLE);
endmodule
